// File: rtl/program_counter_stack.sv
// Program counter with absolute load, signed relative branch and a hardware
// call/return stack. COUNT is the instruction fetch address; the decoder
// drives the strobes, and the control unit watches occupancy and faults.
module program_counter_stack #(
    parameter int                ADDR_W    = 8,
    parameter int                STACK_D   = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                STEP      = 1
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             EN,
    input  logic                             LOAD,
    input  logic [ADDR_W-1:0]                LOAD_ADDR,
    input  logic                             BRANCH,
    input  logic [ADDR_W-1:0]                OFFSET,
    input  logic                             CALL,
    input  logic                             RET,
    input  logic                             FAULT_CLR,
    output logic [ADDR_W-1:0]                COUNT,
    output logic                             ON,
    output logic [$clog2(STACK_D+1)-1:0]     STACK_LVL,
    output logic                             STACK_FULL,
    output logic                             STACK_EMPTY,
    output logic                             FAULT_OVF,
    output logic                             FAULT_UNF
);

    localparam int                LVL_W   = $clog2(STACK_D + 1);
    localparam logic [ADDR_W-1:0] STEP_V  = ADDR_W'(STEP);
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(STACK_D);
    localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);

    logic [ADDR_W-1:0]        count_q, count_d;
    logic [LVL_W-1:0]         lvl_q, lvl_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic [ADDR_W-1:0]        stack_q [STACK_D];

    logic                     full, empty;
    logic                     push;
    logic                     ovf_set, unf_set;
    logic [ADDR_W-1:0]        ret_addr;
    logic [ADDR_W-1:0]        top;
    logic signed [ADDR_W-1:0] count_s;
    logic signed [ADDR_W-1:0] offset_s;

    assign full     = (lvl_q == LVL_MAX);
    assign empty    = (lvl_q == '0);
    assign ret_addr = count_q + STEP_V;
    assign count_s  = $signed(count_q);
    assign offset_s = $signed(OFFSET);

    // Select the top-of-stack entry (index lvl_q-1) without a narrowing index cast
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (lvl_q == LVL_W'(i + 1)) begin
                top = stack_q[i];
            end
        end
    end

    // Choose the single action for this cycle by priority LOAD > CALL > RET > BRANCH > step
    always_comb begin
        count_d = count_q;
        lvl_d   = lvl_q;
        push    = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (LOAD) begin
            count_d = LOAD_ADDR;
        end else if (EN) begin
            if (CALL) begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    push    = 1'b1;
                    lvl_d   = lvl_q + LVL_ONE;
                    count_d = LOAD_ADDR;
                end
            end else if (RET) begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    lvl_d   = lvl_q - LVL_ONE;
                    count_d = top;
                end
            end else if (BRANCH) begin
                // Two's-complement add of equal widths wraps modulo 2^ADDR_W
                count_d = $unsigned(count_s + offset_s);
            end else begin
                count_d = count_q + STEP_V;
            end
        end
        // A fault event in the same cycle as a clear keeps the flag set
        ovf_d = ovf_set | (ovf_q & ~FAULT_CLR);
        unf_d = unf_set | (unf_q & ~FAULT_CLR);
    end

    // Control state: PC, occupancy and sticky faults, asynchronously reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= RESET_VEC;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address storage; contents are meaningless above STACK_LVL so no reset
    always_ff @(posedge CLK) begin
        for (int i = 0; i < STACK_D; i++) begin
            if (push && (lvl_q == LVL_W'(i))) begin
                stack_q[i] <= ret_addr;
            end
        end
    end

    assign COUNT       = count_q;
    assign ON          = EN;
    assign STACK_LVL   = lvl_q;
    assign STACK_FULL  = full;
    assign STACK_EMPTY = empty;
    assign FAULT_OVF   = ovf_q;
    assign FAULT_UNF   = unf_q;

endmodule

// File: tb/tb_program_counter_stack.sv
// Bench for program_counter_stack: directed vector table, hand-written
// reset sequences, then randomized traffic against a queue-based model.
module tb_program_counter_stack;

    localparam int         AW = 8;
    localparam int         SD = 4;
    localparam logic [7:0] RV = 8'h10;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       EN, LOAD, BRANCH, CALL, RET, FAULT_CLR;
    logic [7:0] LOAD_ADDR, OFFSET;
    logic [7:0] COUNT;
    logic       ON;
    logic [2:0] STACK_LVL;
    logic       STACK_FULL, STACK_EMPTY, FAULT_OVF, FAULT_UNF;

    int n_cmp  = 0;
    int n_fail = 0;

    program_counter_stack #(
        .ADDR_W   (AW),
        .STACK_D  (SD),
        .RESET_VEC(RV),
        .STEP     (1)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .EN         (EN),
        .LOAD       (LOAD),
        .LOAD_ADDR  (LOAD_ADDR),
        .BRANCH     (BRANCH),
        .OFFSET     (OFFSET),
        .CALL       (CALL),
        .RET        (RET),
        .FAULT_CLR  (FAULT_CLR),
        .COUNT      (COUNT),
        .ON         (ON),
        .STACK_LVL  (STACK_LVL),
        .STACK_FULL (STACK_FULL),
        .STACK_EMPTY(STACK_EMPTY),
        .FAULT_OVF  (FAULT_OVF),
        .FAULT_UNF  (FAULT_UNF)
    );

    always #5 CLK = ~CLK;

    // Reference model: PC plus a queue used as the return stack
    logic [7:0] m_cnt;
    logic [7:0] m_stk[$];
    logic       m_ovf, m_unf;

    typedef struct {
        logic       en, load;
        logic [7:0] addr;
        logic       call, ret, br;
        logic [7:0] off;
        logic       fclr;
        logic [7:0] e_cnt;
        int         e_lvl;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic en, load, input logic [7:0] addr,
                       input logic call, ret, br, input logic [7:0] off,
                       input logic fclr, input logic [7:0] e_cnt,
                       input int e_lvl, input logic e_ovf, e_unf);
        vec_t v;
        v.en = en; v.load = load; v.addr = addr; v.call = call; v.ret = ret;
        v.br = br; v.off = off; v.fclr = fclr; v.e_cnt = e_cnt;
        v.e_lvl = e_lvl; v.e_ovf = e_ovf; v.e_unf = e_unf;
        vt.push_back(v);
    endtask

    task automatic mdl_reset();
        m_cnt = RV;
        m_stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic mdl_step();
        logic ov, un;
        ov = 1'b0;
        un = 1'b0;
        if (LOAD) begin
            m_cnt = LOAD_ADDR;
        end else if (EN) begin
            if (CALL) begin
                if (m_stk.size() == SD) ov = 1'b1;
                else begin
                    m_stk.push_back(8'((int'(m_cnt) + 1) % 256));
                    m_cnt = LOAD_ADDR;
                end
            end else if (RET) begin
                if (m_stk.size() == 0) un = 1'b1;
                else m_cnt = m_stk.pop_back();
            end else if (BRANCH) begin
                m_cnt = 8'((int'(m_cnt) + int'($signed(OFFSET)) + 256) % 256);
            end else begin
                m_cnt = 8'((int'(m_cnt) + 1) % 256);
            end
        end
        m_ovf = ov | (m_ovf & ~FAULT_CLR);
        m_unf = un | (m_unf & ~FAULT_CLR);
    endtask

    task automatic cmp(input int tag, input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got 0x%0h, expected 0x%0h", tag, nm, act, exp);
        end
    endtask

    task automatic check(input int tag, input logic [7:0] ec, input int el,
                         input logic eo, eu);
        cmp(tag, "COUNT", int'(COUNT), int'(ec));
        cmp(tag, "STACK_LVL", int'(STACK_LVL), el);
        cmp(tag, "FAULT_OVF", int'(FAULT_OVF), int'(eo));
        cmp(tag, "FAULT_UNF", int'(FAULT_UNF), int'(eu));
        cmp(tag, "STACK_FULL", int'(STACK_FULL), (el == SD) ? 1 : 0);
        cmp(tag, "STACK_EMPTY", int'(STACK_EMPTY), (el == 0) ? 1 : 0);
        cmp(tag, "ON", int'(ON), int'(EN));
    endtask

    task automatic drive(input logic en, load, input logic [7:0] addr,
                         input logic call, ret, br, input logic [7:0] off,
                         input logic fclr);
        EN = en; LOAD = load; LOAD_ADDR = addr; CALL = call; RET = ret;
        BRANCH = br; OFFSET = off; FAULT_CLR = fclr;
    endtask

    // One clocked step with explicit expected values
    task automatic tv(input int tag, input logic en, load, input logic [7:0] addr,
                      input logic call, ret, br, input logic [7:0] off,
                      input logic fclr, input logic [7:0] ec, input int el,
                      input logic eo, eu);
        drive(en, load, addr, call, ret, br, off, fclr);
        @(posedge CLK);
        mdl_step();
        #1;
        check(tag, ec, el, eo, eu);
    endtask

    initial begin
        //  en load addr  call ret br off   fclr  cnt  lvl ovf unf
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h11, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h12, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h13, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 8'hFF, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(0, 1, 8'h20, 0, 0, 0, 8'h00, 0, 8'h20, 0, 0, 0);
        add(1, 1, 8'h40, 1, 0, 1, 8'h07, 0, 8'h40, 0, 0, 0);
        add(0, 0, 8'h00, 0, 0, 1, 8'h05, 0, 8'h40, 0, 0, 0);
        add(0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h40, 0, 0, 0);
        add(0, 1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h05, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1, 8'hFA, 0, 8'hFF, 0, 0, 0);
        add(0, 1, 8'hFE, 0, 0, 0, 8'h00, 0, 8'hFE, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 1, 8'h03, 0, 8'h01, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        add(1, 0, 8'h10, 1, 0, 0, 8'h00, 0, 8'h10, 1, 0, 0);
        add(1, 0, 8'h20, 1, 0, 0, 8'h00, 0, 8'h20, 2, 0, 0);
        add(1, 0, 8'h30, 1, 0, 0, 8'h00, 0, 8'h30, 3, 0, 0);
        add(1, 0, 8'h40, 1, 0, 0, 8'h00, 0, 8'h40, 4, 0, 0);
        add(1, 0, 8'h50, 1, 0, 0, 8'h00, 0, 8'h40, 4, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h31, 3, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h21, 2, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h11, 1, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h01, 0, 1, 0);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h01, 0, 1, 1);
        add(1, 0, 8'h00, 0, 1, 0, 8'h00, 1, 8'h01, 0, 0, 1);
        add(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
        add(1, 0, 8'h80, 1, 1, 0, 8'h00, 0, 8'h80, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1, 1, 8'h10, 0, 8'h02, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h03, 0, 0, 0);

        // Reset held with active strobes: all inputs ignored
        RESET_N = 1'b0;
        drive(1, 1, 8'hAA, 1, 0, 0, 8'h00, 0);
        mdl_reset();
        repeat (3) @(posedge CLK);
        #1;
        check(0, RV, 0, 0, 0);
        @(negedge CLK);
        drive(0, 0, 8'h00, 0, 0, 0, 8'h00, 0);
        RESET_N = 1'b1;
        #1;
        check(0, RV, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            tv(i + 1, vt[i].en, vt[i].load, vt[i].addr, vt[i].call, vt[i].ret,
               vt[i].br, vt[i].off, vt[i].fclr,
               vt[i].e_cnt, vt[i].e_lvl, vt[i].e_ovf, vt[i].e_unf);
        end

        // Overflow set wins over a coincident clear
        tv(100, 1, 0, 8'h60, 1, 0, 0, 8'h00, 0, 8'h60, 1, 0, 0);
        tv(101, 1, 0, 8'h61, 1, 0, 0, 8'h00, 0, 8'h61, 2, 0, 0);
        tv(102, 1, 0, 8'h62, 1, 0, 0, 8'h00, 0, 8'h62, 3, 0, 0);
        tv(103, 1, 0, 8'h63, 1, 0, 0, 8'h00, 0, 8'h63, 4, 0, 0);
        tv(104, 1, 0, 8'h64, 1, 0, 0, 8'h00, 1, 8'h63, 4, 1, 0);
        tv(105, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h63, 4, 0, 0);
        tv(106, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h63, 3, 0, 0);
        tv(107, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h62, 2, 0, 0);

        // Asynchronous reset pulse between edges, then an empty RET
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        mdl_reset();
        check(200, RV, 0, 0, 0);
        #1;
        RESET_N = 1'b1;
        tv(201, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, RV, 0, 0, 1);

        // Randomized traffic against the model, with occasional async resets
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(7) != 0), ($urandom_range(15) == 0),
                  8'($urandom_range(255)), ($urandom_range(3) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                  8'($urandom_range(255)), ($urandom_range(15) == 0));
            @(posedge CLK);
            mdl_step();
            #1;
            check(1000 + k, m_cnt, m_stk.size(), m_ovf, m_unf);
            if ($urandom_range(63) == 0) begin
                RESET_N = 1'b0;
                #1;
                mdl_reset();
                check(5000 + k, m_cnt, 0, 0, 0);
                RESET_N = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
- Parametrised successor to the 4-bit program counter.
- Provides a configurable-width PC with absolute load, signed relative branch and a hardware call/return stack of configurable depth.
- Sits between the instruction decoder, which drives the control strobes, and instruction memory, which consumes COUNT as the fetch address.
- Reports stack occupancy and sticky overflow/underflow faults to the control unit.

Parameters:
- ADDR_W, 8: PC and address width in bits; minimum 2.
- STACK_D, 4: return stack depth in entries; minimum 1.
- RESET_VEC, 0: value loaded into the PC at reset; width ADDR_W.
- STEP, 1: increment applied on a normal advance; must be less than 2^ADDR_W.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- EN  in  1  count enable; gates increment, BRANCH, CALL and RET.
- LOAD  in  1  absolute jump: PC <= LOAD_ADDR; acts regardless of EN.
- LOAD_ADDR  in  ADDR_W  jump target for LOAD and CALL.
- BRANCH  in  1  relative jump: PC <= PC + sign-extended OFFSET.
- OFFSET  in  ADDR_W  two's-complement branch offset.
- CALL  in  1  push return address, then jump to LOAD_ADDR.
- RET  in  1  pop the top of stack into the PC.
- FAULT_CLR  in  1  synchronous clear of both fault flags.
- COUNT  out  ADDR_W  current PC (registered).
- ON  out  1  combinational copy of EN.
- STACK_LVL  out  clog2(STACK_D+1)  number of valid stack entries.
- STACK_FULL  out  1  STACK_LVL == STACK_D.
- STACK_EMPTY  out  1  STACK_LVL == 0.
- FAULT_OVF  out  1  sticky flag: CALL attempted while full.
- FAULT_UNF  out  1  sticky flag: RET attempted while empty.

Behaviour:
- Reset (RESET_N low, asynchronous, takes effect immediately):
  - COUNT = RESET_VEC, STACK_LVL = 0, both faults = 0.
  - Stack contents are don't-care.
  - While RESET_N is low, all inputs are ignored.
  - Deassertion is synchronous to CLK; the first update occurs on the first rising edge after release.
- Each cycle exactly one action is taken, chosen by fixed priority: LOAD > CALL > RET > BRANCH > increment.
  - Lower-priority strobes asserted in the same cycle are ignored entirely: no push, no pop, no fault.
  - Every action other than LOAD requires EN = 1; with EN = 0 and LOAD = 0, the PC and stack hold.
- LOAD: COUNT <= LOAD_ADDR. The stack is untouched.
- CALL, stack not full:
  - stack[STACK_LVL] <= COUNT + STEP (mod 2^ADDR_W).
  - STACK_LVL increments.
  - COUNT <= LOAD_ADDR.
- CALL, stack full: COUNT, stack and STACK_LVL hold; FAULT_OVF <= 1.
- RET, stack not empty:
  - COUNT <= stack[STACK_LVL-1].
  - STACK_LVL decrements.
- RET, stack empty: COUNT holds; FAULT_UNF <= 1.
- BRANCH: COUNT <= COUNT + OFFSET, with OFFSET sign-extended and the sum wrapping modulo 2^ADDR_W.
- Increment: COUNT <= COUNT + STEP, wrapping modulo 2^ADDR_W; no flag is raised on wrap.
- Latency: every action takes one cycle; the new COUNT is visible the cycle after the strobe edge.
- Fault flags:
  - Sticky until FAULT_CLR or reset.
  - If FAULT_CLR and a new fault event coincide, the set wins and the flag stays 1.
- Flag decode: STACK_FULL and STACK_EMPTY are combinational decodes of the registered STACK_LVL.
- Stack storage: a register array indexed by STACK_LVL; no external memory.

Test Plan:
- Reset and increment: ADDR_W=8, RESET_VEC=0x10; hold RESET_N low, release, EN=1 for 3 cycles -> COUNT = 0x10, 0x11, 0x12, 0x13. Then preload 0xFF with LOAD and increment -> COUNT = 0x00, no fault.
- Priority: from COUNT=0x20, assert LOAD=1, CALL=1, BRANCH=1 with LOAD_ADDR=0x40 -> COUNT=0x40, STACK_LVL stays 0. Then EN=0 with BRANCH=1 -> COUNT holds at 0x40.
- Branch wrap:
  - From COUNT=0x05, OFFSET=0xFA (-6) -> COUNT=0xFF.
  - From COUNT=0xFE, OFFSET=0x03 -> COUNT=0x01.
- Nested calls (STACK_D=4):
  - From COUNT=0x00, CALL to 0x10, 0x20, 0x30, 0x40 in consecutive cycles -> STACK_LVL=4, STACK_FULL=1.
  - Fifth CALL to 0x50 -> COUNT stays 0x40, FAULT_OVF=1.
  - Four RETs -> COUNT = 0x31, 0x21, 0x11, 0x01; STACK_EMPTY=1.
- Underflow and clear:
  - RET with an empty stack -> COUNT holds, FAULT_UNF=1.
  - FAULT_CLR together with another empty RET -> FAULT_UNF stays 1.
  - FAULT_CLR alone -> FAULT_UNF=0.
- Mid-operation reset: after two CALLs, pulse RESET_N low between clock edges -> COUNT=RESET_VEC and STACK_LVL=0 immediately, without waiting for a clock edge. A following RET -> FAULT_UNF=1.
